// File: rtl/cmd_sched_if.sv
// Request/command handshake bundle for cmd_sched: four requesters in, one
// command stream out to the game engine, plus occupancy/drop status.
interface cmd_sched_if #(
    parameter int DEPTH = 16,
    parameter int CMD_W = 4
);
    logic [3:0]              req_valid;
    logic [4*CMD_W-1:0]      req_cmd;
    logic [3:0]              req_ready;
    logic                    cmd_valid;
    logic [CMD_W-1:0]        cmd;
    logic                    cmd_ready;
    logic [$clog2(DEPTH):0]  level;
    logic [7:0]              drop_cnt;

    modport master (
        output req_valid, req_cmd, cmd_ready,
        input  req_ready, cmd_valid, cmd, level, drop_cnt
    );

    modport slave (
        input  req_valid, req_cmd, cmd_ready,
        output req_ready, cmd_valid, cmd, level, drop_cnt
    );
endinterface

// File: rtl/cmd_sched.sv
// Round-robin command scheduler feeding a FIFO to the game engine.
// Optional CMD_SCHED_COALESCE_EN: drop requester-3 commands equal to the FIFO tail.
module cmd_sched #(
    parameter int DEPTH = 16,
    parameter int CMD_W = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic       flush,
    cmd_sched_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [CMD_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level_q;
    logic [1:0]       rr_ptr;
    logic [7:0]       drop_q;

    logic [3:0]       grant;
    logic [1:0]       grant_idx;
    logic             grant_any;
    logic [CMD_W-1:0] grant_cmd;
    logic             head_valid;
    logic             push;
    logic             pop;
    logic             drop;

    assign head_valid = (level_q != '0);

    // Full blocks grants even when a pop happens in the same cycle.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        if (reset_n && en && !flush && (level_q != FULL_LVL)) begin
            for (int unsigned i = 1; i <= 4; i++) begin
                if (!grant_any && bus.req_valid[rr_ptr + 2'(i)]) begin
                    grant_any = 1'b1;
                    grant_idx = rr_ptr + 2'(i);
                end
            end
            if (grant_any)
                grant[grant_idx] = 1'b1;
        end
    end

    assign grant_cmd = bus.req_cmd[grant_idx*CMD_W +: CMD_W];

`ifdef CMD_SCHED_COALESCE_EN
    logic coalesce;
    assign coalesce = (grant_idx == 2'd3) && head_valid &&
                      (grant_cmd == mem[wr_ptr - AW'(1)]);
    assign push = grant_any && (grant_cmd != '0) && !coalesce;
`else
    assign push = grant_any && (grant_cmd != '0);
`endif

    assign drop = grant_any && !push;
    assign pop  = head_valid && bus.cmd_ready && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            rr_ptr  <= 2'd3;
            drop_q  <= '0;
        end else begin
            if (grant_any)
                rr_ptr <= grant_idx;
            if (drop && (drop_q != '1))
                drop_q <= drop_q + 8'd1;
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                level_q <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                if (push && !pop)
                    level_q <= level_q + (AW+1)'(1);
                else if (pop && !push)
                    level_q <= level_q - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= grant_cmd;
    end

    assign bus.req_ready = grant;
    assign bus.cmd_valid = head_valid;
    assign bus.cmd       = head_valid ? mem[rd_ptr] : '0;
    assign bus.level     = level_q;
    assign bus.drop_cnt  = drop_q;
endmodule

// File: tb/tb_cmd_sched.sv
// Directed bench for cmd_sched (DEPTH=16, CMD_W=5); honours CMD_SCHED_COALESCE_EN.
module tb_cmd_sched;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic clk;
    logic reset_n;
    logic en;
    logic flush;
    int   errors;
    int   checks;
    int   exp_drop;

    cmd_sched_if #(.DEPTH(DEPTH), .CMD_W(CW)) bus ();

    cmd_sched #(.DEPTH(DEPTH), .CMD_W(CW)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (en),
        .flush  (flush),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_fifo();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        en            = 1'b1;
        flush         = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_cmd   = {5'd4, 5'd3, 5'd2, 5'd1};
        bus.cmd_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b want=0000", bus.req_ready); end
        checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid got=%b want=0", bus.cmd_valid); end
        checks++; if (bus.cmd !== 5'd0) begin errors++; $display("FAIL reset_cmd got=%0d want=0", bus.cmd); end
        checks++; if (bus.level !== 5'd0) begin errors++; $display("FAIL reset_level got=%0d want=0", bus.level); end
        checks++; if (bus.drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got=%0d want=0", bus.drop_cnt); end
        reset_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        logic [4:0] exp_c;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rr_first_grant got=%b want=0001", bus.req_ready); end
        checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL rr_first_empty got=%b want=0", bus.cmd_valid); end
        step();
        for (int k = 1; k < 9; k++) begin
            exp_g = 4'b0001 << (k % 4);
            exp_c = 5'((k - 1) % 4 + 1);
            checks++; if (bus.req_ready !== exp_g) begin errors++; $display("FAIL rr_grant[%0d] got=%b want=%b", k, bus.req_ready, exp_g); end
            checks++; if (bus.cmd !== exp_c) begin errors++; $display("FAIL rr_cmd[%0d] got=%0d want=%0d", k, bus.cmd, exp_c); end
            checks++; if (bus.level !== 5'd1) begin errors++; $display("FAIL rr_level[%0d] got=%0d want=1", k, bus.level); end
            step();
        end
        bus.req_valid = 4'b0000;
        flush_fifo();
    endtask

    task automatic test_full();
        bus.cmd_ready = 1'b0;
        bus.req_valid = 4'b0100;
        for (int n = 1; n <= 16; n++) begin
            bus.req_cmd = '0;
            bus.req_cmd[2*CW +: CW] = CW'(n);
            #1;
            checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL full_fill_grant[%0d] got=%b want=0100", n, bus.req_ready); end
            step();
        end
        checks++; if (bus.level !== 5'd16) begin errors++; $display("FAIL full_level got=%0d want=16", bus.level); end
        bus.req_cmd[2*CW +: CW] = 5'd17;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL full_no_grant got=%b want=0000", bus.req_ready); end
        step();
        checks++; if (bus.level !== 5'd16) begin errors++; $display("FAIL full_level_hold got=%0d want=16", bus.level); end
        bus.cmd_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL full_pop_no_grant got=%b want=0000", bus.req_ready); end
        checks++; if (bus.cmd !== 5'd1) begin errors++; $display("FAIL full_head got=%0d want=1", bus.cmd); end
        step();
        checks++; if (bus.level !== 5'd15) begin errors++; $display("FAIL full_after_pop got=%0d want=15", bus.level); end
        bus.cmd_ready = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL full_17th_grant got=%b want=0100", bus.req_ready); end
        step();
        checks++; if (bus.level !== 5'd16) begin errors++; $display("FAIL full_refill got=%0d want=16", bus.level); end
        bus.req_valid = 4'b0000;
        bus.cmd_ready = 1'b1;
        for (int k = 2; k <= 17; k++) begin
            checks++; if (bus.cmd !== CW'(k)) begin errors++; $display("FAIL full_drain[%0d] got=%0d want=%0d", k, bus.cmd, k); end
            step();
        end
        checks++; if (bus.level !== 5'd0) begin errors++; $display("FAIL full_drained_level got=%0d want=0", bus.level); end
        checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL full_drained_valid got=%b want=0", bus.cmd_valid); end
    endtask

    task automatic test_drop();
        flush_fifo();
        bus.cmd_ready = 1'b0;
        bus.req_cmd   = '0;
        bus.req_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL drop_grant[%0d] got=%b want=0001", k, bus.req_ready); end
            step();
            exp_drop++;
        end
        bus.req_valid = 4'b0000;
        checks++; if (bus.drop_cnt !== 8'(exp_drop)) begin errors++; $display("FAIL drop_cnt got=%0d want=%0d", bus.drop_cnt, exp_drop); end
        checks++; if (bus.level !== 5'd0) begin errors++; $display("FAIL drop_level got=%0d want=0", bus.level); end
    endtask

    task automatic test_coalesce();
        flush_fifo();
        bus.cmd_ready = 1'b0;
        bus.req_cmd   = '0;
        bus.req_cmd[3*CW +: CW] = 5'd2;
        bus.req_valid = 4'b1000;
        repeat (4) step();
        bus.req_valid = 4'b0000;
`ifdef CMD_SCHED_COALESCE_EN
        exp_drop += 3;
        checks++; if (bus.level !== 5'd1) begin errors++; $display("FAIL coalesce_level got=%0d want=1", bus.level); end
`else
        checks++; if (bus.level !== 5'd4) begin errors++; $display("FAIL coalesce_level got=%0d want=4", bus.level); end
`endif
        checks++; if (bus.drop_cnt !== 8'(exp_drop)) begin errors++; $display("FAIL coalesce_drop got=%0d want=%0d", bus.drop_cnt, exp_drop); end
    endtask

    task automatic test_flush();
        flush_fifo();
        bus.cmd_ready = 1'b0;
        bus.req_valid = 4'b0001;
        for (int n = 1; n <= 5; n++) begin
            bus.req_cmd = '0;
            bus.req_cmd[0 +: CW] = CW'(n);
            step();
        end
        checks++; if (bus.level !== 5'd5) begin errors++; $display("FAIL flush_pre_level got=%0d want=5", bus.level); end
        flush = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL flush_no_grant got=%b want=0000", bus.req_ready); end
        step();
        flush = 1'b0;
        bus.req_valid = 4'b0000;
        #1;
        checks++; if (bus.level !== 5'd0) begin errors++; $display("FAIL flush_level got=%0d want=0", bus.level); end
        checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b want=0", bus.cmd_valid); end
        checks++; if (bus.cmd !== 5'd0) begin errors++; $display("FAIL flush_cmd got=%0d want=0", bus.cmd); end
        checks++; if (bus.drop_cnt !== 8'(exp_drop)) begin errors++; $display("FAIL flush_drop_kept got=%0d want=%0d", bus.drop_cnt, exp_drop); end
    endtask

    task automatic test_push_pop();
        flush_fifo();
        bus.cmd_ready = 1'b0;
        bus.req_valid = 4'b0010;
        bus.req_cmd   = '0;
        bus.req_cmd[CW +: CW] = 5'd7;
        step();
        bus.req_cmd[CW +: CW] = 5'd9;
        bus.cmd_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL pp_grant got=%b want=0010", bus.req_ready); end
        checks++; if (bus.cmd !== 5'd7) begin errors++; $display("FAIL pp_head got=%0d want=7", bus.cmd); end
        step();
        bus.req_valid = 4'b0000;
        bus.cmd_ready = 1'b0;
        checks++; if (bus.level !== 5'd1) begin errors++; $display("FAIL pp_level got=%0d want=1", bus.level); end
        checks++; if (bus.cmd !== 5'd9) begin errors++; $display("FAIL pp_new_head got=%0d want=9", bus.cmd); end
    endtask

    task automatic test_en_drain();
        flush_fifo();
        bus.cmd_ready = 1'b0;
        bus.req_valid = 4'b0010;
        for (int n = 10; n <= 12; n++) begin
            bus.req_cmd = '0;
            bus.req_cmd[CW +: CW] = CW'(n);
            step();
        end
        checks++; if (bus.level !== 5'd3) begin errors++; $display("FAIL en_pre_level got=%0d want=3", bus.level); end
        en            = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_cmd   = {5'd4, 5'd3, 5'd2, 5'd1};
        bus.cmd_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL en_no_grant[%0d] got=%b want=0000", k, bus.req_ready); end
            checks++; if (bus.cmd !== CW'(10 + k)) begin errors++; $display("FAIL en_drain[%0d] got=%0d want=%0d", k, bus.cmd, 10 + k); end
            step();
        end
        checks++; if (bus.level !== 5'd0) begin errors++; $display("FAIL en_drained got=%0d want=0", bus.level); end
        en            = 1'b1;
        bus.req_valid = 4'b0000;
        bus.cmd_ready = 1'b0;
    endtask

    task automatic test_saturate();
        flush_fifo();
        bus.req_cmd   = '0;
        bus.req_valid = 4'b0001;
        repeat (260) step();
        bus.req_valid = 4'b0000;
        checks++; if (bus.drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_saturate got=%0d want=255", bus.drop_cnt); end
    endtask

    task automatic test_async_reset();
        bus.cmd_ready = 1'b0;
        bus.req_valid = 4'b0001;
        bus.req_cmd   = '0;
        bus.req_cmd[0 +: CW] = 5'd3;
        repeat (2) step();
        checks++; if (bus.level !== 5'd2) begin errors++; $display("FAIL ar_pre_level got=%0d want=2", bus.level); end
        #2;
        reset_n       = 1'b0;
        bus.req_valid = 4'b1111;
        #1;
        checks++; if (bus.level !== 5'd0) begin errors++; $display("FAIL ar_level got=%0d want=0", bus.level); end
        checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got=%b want=0", bus.cmd_valid); end
        checks++; if (bus.cmd !== 5'd0) begin errors++; $display("FAIL ar_cmd got=%0d want=0", bus.cmd); end
        checks++; if (bus.drop_cnt !== 8'd0) begin errors++; $display("FAIL ar_drop got=%0d want=0", bus.drop_cnt); end
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL ar_req_ready got=%b want=0000", bus.req_ready); end
        bus.req_valid = 4'b0000;
        #1;
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        exp_drop = 0;
        test_reset();
        test_round_robin();
        test_full();
        test_drop();
        test_coalesce();
        test_flush();
        test_push_pop();
        test_en_drain();
        test_saturate();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
